// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master: funct3 size codes,
// decoded access size and the FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Unknown funct3 encodings fall back to a full-word access.
    function automatic size_e f3_size(input logic [2:0] f3);
        size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            F3_W:        sz = SZ_W;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Single-beat request channel (valid/ready) plus valid-only response channel
// between the load/store unit and the data memory.
interface lsu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of a
// full memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    // Select the lane, then extend; funct3[2] marks the unsigned variants.
    always_comb begin
        byte_sel = lane[offset];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        sign_ext = ~func3[2];
        case (f3_size(func3))
            SZ_B:    data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_H:    data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: turns an execute-stage load or store into one
// bus request, stalls the core until the response (or a timeout) arrives and
// returns the aligned load result for one DONE cycle.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  func3,
    input  logic [31:0] alu_result,
    input  logic [31:0] rd_data2,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    lsu_bus_master_if.master bus
);

    state_e      state_reg;
    logic        req_valid_reg;
    logic        req_we_reg;
    logic [31:0] req_addr_reg;
    logic [3:0]  req_be_reg;
    logic [31:0] req_wdata_reg;
    logic [31:0] load_data_reg;
    logic        bus_err_reg;
    logic [1:0]  off_reg;
    logic [2:0]  f3_reg;
    logic [CNT_W-1:0] cnt_reg;

    size_e       req_size;
    logic        access;
    logic        issue;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] align_data;

    assign bus.req_valid = req_valid_reg;
    assign bus.req_we    = req_we_reg;
    assign bus.req_addr  = req_addr_reg;
    assign bus.req_be    = req_be_reg;
    assign bus.req_wdata = req_wdata_reg;
    assign load_data     = load_data_reg;
    assign bus_err       = bus_err_reg;

    // Format the returning word with the offset/size captured at issue time.
    lsu_load_align u_align (
        .word   (bus.resp_rdata),
        .offset (off_reg),
        .func3  (f3_reg),
        .data   (align_data)
    );

    // Decode the incoming access: alignment, issue decision, stall and store lanes.
    always_comb begin
        req_size   = f3_size(func3);
        access     = mem_rd | mem_wr;
        misaligned = (state_reg == ST_IDLE) & access &
                     (((req_size == SZ_H) & alu_result[0]) |
                      ((req_size == SZ_W) & (alu_result[1:0] != 2'b00)));
        issue      = (state_reg == ST_IDLE) & access & ~misaligned;
        stall      = issue | (state_reg == ST_REQ) | (state_reg == ST_WAIT);

        be_next    = 4'b1111;
        wdata_next = 32'h0;
        if (mem_wr) begin
            case (req_size)
                SZ_B: begin
                    be_next    = 4'b0001 << alu_result[1:0];
                    wdata_next = {4{rd_data2[7:0]}};
                end
                SZ_H: begin
                    be_next    = alu_result[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{rd_data2[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = rd_data2;
                end
            endcase
        end

        // Counter started at 0 on the first REQ cycle, so TIMEOUT-1 marks the
        // last permitted cycle in REQ/WAIT.
        timeout_hit = (cnt_reg >= CNT_W'(TIMEOUT - 1));
    end

    // Request FSM with registered bus fields, load result and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            req_valid_reg <= 1'b0;
            req_we_reg    <= 1'b0;
            req_addr_reg  <= 32'h0;
            req_be_reg    <= 4'h0;
            req_wdata_reg <= 32'h0;
            load_data_reg <= 32'h0;
            bus_err_reg   <= 1'b0;
            off_reg       <= 2'b00;
            f3_reg        <= 3'b000;
            cnt_reg       <= '0;
        end else begin
            bus_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (issue) begin
                        req_valid_reg <= 1'b1;
                        req_we_reg    <= mem_wr;
                        req_addr_reg  <= {alu_result[31:2], 2'b00};
                        req_be_reg    <= be_next;
                        req_wdata_reg <= wdata_next;
                        off_reg       <= alu_result[1:0];
                        f3_reg        <= func3;
                        cnt_reg       <= '0;
                        state_reg     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A response in the acceptance cycle is deliberately dropped.
                    if (bus.req_ready) begin
                        req_valid_reg <= 1'b0;
                        cnt_reg       <= cnt_reg + CNT_W'(1);
                        state_reg     <= req_we_reg ? ST_DONE : ST_WAIT;
                    end else if (timeout_hit) begin
                        req_valid_reg <= 1'b0;
                        load_data_reg <= 32'h0;
                        bus_err_reg   <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (bus.resp_valid) begin
                        load_data_reg <= align_data;
                        state_reg     <= ST_DONE;
                    end else if (timeout_hit) begin
                        load_data_reg <= 32'h0;
                        bus_err_reg   <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    // DONE: one unstalled cycle for the core to commit.
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: stores, loads of every size, misaligned
// rejection, request back-pressure, timeout and reset during a pending read.
module tb_lsu_bus_master;

    logic        clk;
    logic        rst_n;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  func3;
    logic [31:0] alu_result;
    logic [31:0] rd_data2;
    logic        stall;
    logic [31:0] load_data;
    logic        misaligned;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    lsu_bus_master_if bus_if ();

    lsu_bus_master #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .func3      (func3),
        .alu_result (alu_result),
        .rd_data2   (rd_data2),
        .stall      (stall),
        .load_data  (load_data),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .bus        (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle two time units past the edge.
    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    // One load with the response delivered after 'waits' empty WAIT cycles.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input int waits, input logic [31:0] exp);
        mem_rd = 1'b1; func3 = f3; alu_result = addr;
        bus_if.req_ready = 1'b1;
        #1;
        chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
        cyc;
        mem_rd = 1'b0;
        chk({tag, "_req_valid"}, 32'(bus_if.req_valid), 32'd1);
        chk({tag, "_req_addr"}, bus_if.req_addr, {addr[31:2], 2'b00});
        chk({tag, "_req_be"}, 32'(bus_if.req_be), 32'hF);
        chk({tag, "_req_we"}, 32'(bus_if.req_we), 32'd0);
        // Response coinciding with acceptance must be ignored.
        bus_if.resp_valid = 1'b1; bus_if.resp_rdata = 32'hDEADBEEF;
        cyc;
        bus_if.resp_valid = 1'b0; bus_if.req_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_wait_stall"}, 32'(stall), 32'd1);
            chk({tag, "_wait_valid"}, 32'(bus_if.req_valid), 32'd0);
            cyc;
        end
        bus_if.resp_valid = 1'b1; bus_if.resp_rdata = word;
        chk({tag, "_resp_stall"}, 32'(stall), 32'd1);
        cyc;
        bus_if.resp_valid = 1'b0;
        $display("load %s addr=%h word=%h load_data=%h", tag, addr, word, load_data);
        chk({tag, "_data"}, load_data, exp);
        chk({tag, "_done_stall"}, 32'(stall), 32'd0);
        chk({tag, "_done_err"}, 32'(bus_err), 32'd0);
        cyc;
        chk({tag, "_idle_after"}, 32'(stall), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; func3 = 3'b000;
        alu_result = 32'h0; rd_data2 = 32'h0;
        bus_if.req_ready = 1'b0; bus_if.resp_valid = 1'b0; bus_if.resp_rdata = 32'h0;
        #1;
        chk("rst_req_valid", 32'(bus_if.req_valid), 32'd0);
        chk("rst_req_we", 32'(bus_if.req_we), 32'd0);
        chk("rst_req_addr", bus_if.req_addr, 32'h0);
        chk("rst_req_be", 32'(bus_if.req_be), 32'h0);
        chk("rst_req_wdata", bus_if.req_wdata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        cyc; cyc;
        rst_n = 1'b1;
        cyc;

        // SB to 0x102 with memory ready: REQ then DONE.
        mem_wr = 1'b1; func3 = 3'b000; alu_result = 32'h102; rd_data2 = 32'h000000A5;
        bus_if.req_ready = 1'b1;
        #1;
        chk("sb_idle_stall", 32'(stall), 32'd1);
        chk("sb_misaligned", 32'(misaligned), 32'd0);
        cyc;
        mem_wr = 1'b0;
        $display("store SB addr=%h be=%b wdata=%h", bus_if.req_addr, bus_if.req_be, bus_if.req_wdata);
        chk("sb_req_valid", 32'(bus_if.req_valid), 32'd1);
        chk("sb_req_we", 32'(bus_if.req_we), 32'd1);
        chk("sb_req_addr", bus_if.req_addr, 32'h100);
        chk("sb_req_be", 32'(bus_if.req_be), 32'b0100);
        chk("sb_req_wdata", bus_if.req_wdata, 32'hA5A5A5A5);
        chk("sb_req_stall", 32'(stall), 32'd1);
        cyc;
        chk("sb_done_valid", 32'(bus_if.req_valid), 32'd0);
        chk("sb_done_stall", 32'(stall), 32'd0);
        chk("sb_done_err", 32'(bus_err), 32'd0);
        chk("sb_load_data", load_data, 32'h0);
        cyc;
        bus_if.req_ready = 1'b0;

        // Loads of each size; byte/half lanes of 0x80123456 worked out by hand.
        do_load("lb",  3'b000, 32'h103, 32'h80123456, 3, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 32'h80123456, 3, 32'h00000080);
        do_load("lb1", 3'b000, 32'h101, 32'h80123456, 0, 32'h00000034);
        do_load("lh0", 3'b001, 32'h300, 32'h80123456, 1, 32'h00003456);
        do_load("lh2", 3'b001, 32'h302, 32'h80123456, 1, 32'hFFFF8012);
        do_load("lhu", 3'b101, 32'h302, 32'h80123456, 2, 32'h00008012);
        do_load("lw",  3'b010, 32'h304, 32'h80123456, 0, 32'h80123456);

        // Misaligned LH and SW: no bus access, no stall.
        mem_rd = 1'b1; func3 = 3'b001; alu_result = 32'h201;
        #1;
        chk("lh_mis_flag", 32'(misaligned), 32'd1);
        chk("lh_mis_stall", 32'(stall), 32'd0);
        cyc;
        chk("lh_mis_valid", 32'(bus_if.req_valid), 32'd0);
        mem_rd = 1'b0;
        mem_wr = 1'b1; func3 = 3'b010; alu_result = 32'h202;
        #1;
        $display("misaligned SW addr=%h misaligned=%b", alu_result, misaligned);
        chk("sw_mis_flag", 32'(misaligned), 32'd1);
        chk("sw_mis_stall", 32'(stall), 32'd0);
        cyc;
        chk("sw_mis_valid", 32'(bus_if.req_valid), 32'd0);
        mem_wr = 1'b0;
        #1;
        chk("mis_clear", 32'(misaligned), 32'd0);

        // SH held off by req_ready for three cycles; fields must stay latched.
        mem_wr = 1'b1; func3 = 3'b001; alu_result = 32'h2; rd_data2 = 32'h00001234;
        bus_if.req_ready = 1'b0;
        cyc;
        mem_wr = 1'b0; rd_data2 = 32'h55555555; alu_result = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            $display("store SH hold %0d addr=%h be=%b wdata=%h", i, bus_if.req_addr, bus_if.req_be, bus_if.req_wdata);
            chk("sh_hold_valid", 32'(bus_if.req_valid), 32'd1);
            chk("sh_hold_addr", bus_if.req_addr, 32'h0);
            chk("sh_hold_be", 32'(bus_if.req_be), 32'b1100);
            chk("sh_hold_wdata", bus_if.req_wdata, 32'h12341234);
            chk("sh_hold_stall", 32'(stall), 32'd1);
            cyc;
        end
        bus_if.req_ready = 1'b1;
        chk("sh_accept_valid", 32'(bus_if.req_valid), 32'd1);
        cyc;
        bus_if.req_ready = 1'b0;
        chk("sh_done_valid", 32'(bus_if.req_valid), 32'd0);
        chk("sh_done_stall", 32'(stall), 32'd0);
        chk("sh_keeps_load", load_data, 32'h80123456);
        cyc;

        // Both strobes high: the store wins.
        mem_rd = 1'b1; mem_wr = 1'b1; func3 = 3'b010; alu_result = 32'h600;
        rd_data2 = 32'hCAFEF00D; bus_if.req_ready = 1'b1;
        cyc;
        mem_rd = 1'b0; mem_wr = 1'b0;
        $display("store rd+wr addr=%h we=%b wdata=%h", bus_if.req_addr, bus_if.req_we, bus_if.req_wdata);
        chk("both_we", 32'(bus_if.req_we), 32'd1);
        chk("both_be", 32'(bus_if.req_be), 32'hF);
        chk("both_wdata", bus_if.req_wdata, 32'hCAFEF00D);
        cyc; cyc;
        bus_if.req_ready = 1'b0;

        // Read never accepted: 16 cycles in REQ, then DONE with bus_err.
        mem_rd = 1'b1; func3 = 3'b010; alu_result = 32'h400;
        cyc;
        mem_rd = 1'b0;
        n = 0;
        while (bus_if.req_valid && n < 40) begin
            n++;
            cyc;
        end
        $display("timeout after %0d cycles bus_err=%b load_data=%h", n, bus_err, load_data);
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_load_data", load_data, 32'h0);
        chk("to_done_stall", 32'(stall), 32'd0);
        cyc;
        chk("to_err_pulse", 32'(bus_err), 32'd0);
        chk("to_idle_stall", 32'(stall), 32'd0);

        // Load an easily recognised value, then reset while waiting on a read.
        do_load("pre", 3'b010, 32'h500, 32'h13579BDF, 0, 32'h13579BDF);
        mem_rd = 1'b1; func3 = 3'b010; alu_result = 32'h504; bus_if.req_ready = 1'b1;
        cyc;
        mem_rd = 1'b0;
        cyc;
        bus_if.req_ready = 1'b0;
        chk("rw_wait_stall", 32'(stall), 32'd1);
        cyc;
        rst_n = 1'b0;
        #1;
        $display("reset mid-WAIT stall=%b req_valid=%b load_data=%h", stall, bus_if.req_valid, load_data);
        chk("rw_stall", 32'(stall), 32'd0);
        chk("rw_valid", 32'(bus_if.req_valid), 32'd0);
        chk("rw_load_data", load_data, 32'h0);
        cyc;
        rst_n = 1'b1;
        cyc;
        bus_if.resp_valid = 1'b1; bus_if.resp_rdata = 32'hFFFFFFFF;
        cyc;
        bus_if.resp_valid = 1'b0;
        chk("late_resp_data", load_data, 32'h0);
        chk("late_resp_stall", 32'(stall), 32'd0);
        chk("late_resp_valid", 32'(bus_if.req_valid), 32'd0);
        cyc;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Core-side load/store initiator that issues single-beat requests to a word-organised, multi-cycle data memory over a valid/ready request channel and a valid-only response channel.
- For stores: generates byte enables and lane-replicated write data. For loads: extracts and sign/zero-extends the addressed byte/halfword.
- Stalls the core until the access completes or times out.
- Sits between the execute stage (ALU address, rs2 data, funct3) and the data RAM port.

Parameters:
- TIMEOUT, 16, max cycles spent in REQ+WAIT before forced completion with bus_err.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_rd  in  1  load requested this cycle.
- mem_wr  in  1  store requested this cycle; wins if both mem_rd and mem_wr are high.
- func3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other values are treated as W.
- alu_result  in  32  byte address.
- rd_data2  in  32  store data (rs2).
- stall  out  1  holds the core PC/pipeline.
- load_data  out  32  aligned/extended load result, valid in DONE.
- misaligned  out  1  combinational alignment flag; no bus access is made.
- bus_err  out  1  one-cycle pulse in DONE after a timeout.
- req_valid  out  1  request valid.
- req_ready  in  1  memory accepts the request.
- req_we  out  1  1 = write.
- req_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- req_be  out  4  byte enables.
- req_wdata  out  32  lane-replicated write data.
- resp_valid  in  1  read data valid.
- resp_rdata  in  32  full word read.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registered outputs cleared (req_valid=0, req_we=0, req_addr=0, req_be=0, req_wdata=0, load_data=0, bus_err=0); counter=0.
- misaligned = (mem_rd|mem_wr) & ((size H & addr[0]) | (size W & addr[1:0]!=0)). Evaluated only in IDLE; forced 0 in other states.
- Store lane generation:
  - SB: be=1<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=addr[1] ? 1100 : 0011, wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Reads: req_be=1111.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if (mem_rd|mem_wr) & ~misaligned, latch addr/func3/we/be/wdata, assert stall (combinational), go to REQ. If misaligned: stall=0, stay in IDLE.
  - REQ: req_valid=1 and stall=1. All req_* fields stay stable until accepted. On req_ready: a write goes to DONE, a read goes to WAIT.
  - WAIT: stall=1. On resp_valid, load_data <= extract(resp_rdata, addr[1:0], func3), then go to DONE. resp_valid is ignored in every other state.
  - DONE: stall=0 for exactly one cycle so the core commits; then IDLE. mem_rd/mem_wr seen in DONE are ignored, because they still belong to the completing instruction.
- Timeout: counter is cleared on entry to REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT: drop req_valid, load_data=0, bus_err=1 in DONE, go to DONE.
- Load extraction:
  - B/BU: byte addr[1:0]; sign-extend if func3[2]=0.
  - H/HU: halfword addr[1]; sign-extend if func3[2]=0.
  - W: whole word.
- Latency: store takes 2 cycles with req_ready already high at REQ (REQ, DONE). Load takes 3 cycles plus memory latency.
- Stores leave load_data unchanged.
- req_ready and resp_valid arriving in the same cycle while in REQ: the response is ignored. The memory must return data strictly after acceptance.

Decomposition:
- Shared package lsu_pkg: funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and FSM state encodings.
- One natural sub-module: lsu_load_align, a combinational extract/extend of word, addr[1:0], and func3.

Test Plan:
- SB rs2=0x000000A5, addr=0x102, req_ready=1 → req_addr=0x100, be=0100, wdata=0xA5A5A5A5, stall high 1 cycle, req_valid 1 cycle.
- LB addr=0x103, resp_rdata=0x80123456 after 3 wait cycles → load_data=0xFFFFFF80. Same access as LBU → 0x00000080. stall high for REQ + 4 WAIT cycles.
- LH addr=0x201 → misaligned=1, req_valid never asserts, stall=0. SW addr=0x202 → misaligned=1.
- req_ready held low 3 cycles on SH rs2=0x1234, addr=0x2 → req_addr, be=1100 and wdata=0x12341234 stay stable until acceptance.
- Read with resp_valid never asserted → after TIMEOUT=16 cycles: DONE, bus_err=1 for one cycle, load_data=0, return to IDLE.
- rst_n low mid-WAIT → req_valid=0 and stall=0 immediately. A late resp_valid after reset release is ignored.
